// File: rtl/mem_bist_master.sv
// Memory built-in self-test sequencer.
// Writes (seed + address) to every word of a single-port valid/ready memory,
// reads every word back, and reports pass/fail, mismatch count, first failing
// address and handshake timeout. All outputs are registered.
module mem_bist_master #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [WIDTH-1:0]      seed_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] idx_next;
    logic                  mismatch;

    // Test pattern: seed plus address, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      seed,
                                                 input logic [ADDR_WIDTH-1:0] a);
        return seed + WIDTH'(a);
    endfunction

    assign idx_next = idx + IDX_ONE;
    assign mismatch = (rdata_i != pattern(seed_q, idx));

    // Sequencer FSM; every memory-facing and status output is a register here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            seed_q      <= '0;
            wait_cnt    <= '0;
            valid_o     <= 1'b0;
            wr_rd_o     <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_cnt_o   <= '0;
            fail_addr_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A start in DONE wins over any ready that happens to be present.
                    if (start_i) begin
                        seed_q      <= seed_i;
                        idx         <= '0;
                        err_cnt_o   <= '0;
                        fail_addr_o <= '0;
                        timeout_o   <= 1'b0;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        busy_o      <= 1'b1;
                        valid_o     <= 1'b1;
                        wr_rd_o     <= 1'b1;
                        addr_o      <= '0;
                        wdata_o     <= seed_i;
                        state       <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    valid_o  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (ready_i) begin
                        valid_o <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx     <= '0;
                            wr_rd_o <= 1'b0;
                            addr_o  <= '0;
                            state   <= RD_ISSUE;
                        end else begin
                            idx     <= idx_next;
                            addr_o  <= idx_next;
                            wdata_o <= pattern(seed_q, idx_next);
                            state   <= WR_ISSUE;
                        end
                    end else if (wait_cnt == TMO_LAST) begin
                        // Lost handshake: abandon the remaining transactions.
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        pass_o    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                RD_ISSUE: begin
                    valid_o  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ready_i) begin
                        if (mismatch) begin
                            err_cnt_o <= err_cnt_o + ERR_ONE;
                            if (err_cnt_o == '0) begin
                                fail_addr_o <= idx;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            pass_o <= (err_cnt_o == '0) && !mismatch;
                            state  <= DONE;
                        end else begin
                            idx     <= idx_next;
                            addr_o  <= idx_next;
                            valid_o <= 1'b1;
                            state   <= RD_ISSUE;
                        end
                    end else if (wait_cnt == TMO_LAST) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        pass_o    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural memory with programmable wait states
// and fault injection, reference model of the whole BIST run, and a
// queue-based monitor that checks every request and every completion.
module tb_mem_bist_master;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int TMO   = 8;

    logic          clk;
    logic          rst_i;
    logic          start_i;
    logic [7:0]    seed_i;
    logic          ready_i;
    logic [7:0]    rdata_i;
    logic          valid_o;
    logic          wr_rd_o;
    logic [AW-1:0] addr_o;
    logic [7:0]    wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] fail_addr_o;
    logic          timeout_o;

    mem_bist_master #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
        .ready_i(ready_i), .rdata_i(rdata_i), .valid_o(valid_o), .wr_rd_o(wr_rd_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int addr;
        int data;
    } txn_t;

    typedef struct {
        int err;
        int faddr;
        bit pass;
        bit tmo;
        int done_cyc;
    } stat_t;

    txn_t  exp_txn[$];
    stat_t exp_stat[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    cyc     = 0;

    logic [7:0] mem[DEPTH];
    int         dl[2*DEPTH];
    int         mem_txn = 0;
    bit         tie_low = 1'b0;
    bit         fault   = 1'b0;
    bit         done_prev = 1'b0;

    logic       m_wr;
    int         m_a;
    logic [7:0] m_d;
    int         m_dly;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: answers each sampled request after dl[] wait cycles.
    always begin
        @(posedge clk);
        if (valid_o === 1'b1 && !tie_low) begin
            m_wr  = wr_rd_o;
            m_a   = int'(addr_o);
            m_d   = wdata_o;
            m_dly = (mem_txn < 2*DEPTH) ? dl[mem_txn] : 0;
            mem_txn++;
            if (m_wr) mem[m_a] = (fault && m_a == 5) ? (m_d & 8'hFE) : m_d;
            repeat (m_dly) @(posedge clk);
            #1;
            ready_i = 1'b1;
            if (m_wr) rdata_i = 8'($urandom);
            else if (fault && m_a == 9) rdata_i = 8'hFF;
            else rdata_i = mem[m_a];
            @(posedge clk);
            #1;
            ready_i = 1'b0;
        end
    end

    // Monitor: every request and every rising done is matched against the queues.
    always @(negedge clk) begin : monitor
        txn_t  t;
        stat_t s;
        if (valid_o === 1'b1) begin
            if (exp_txn.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_req actual=wr%0d/addr%0d required=no request (t=%0t)",
                         wr_rd_o, addr_o, $time);
            end else begin
                t = exp_txn.pop_front();
                chk("req_wr", int'(wr_rd_o), int'(t.wr));
                chk("req_addr", int'(addr_o), t.addr);
                if (t.wr) chk("req_wdata", int'(wdata_o), t.data);
            end
        end
        if (done_o === 1'b1 && !done_prev) begin
            if (exp_stat.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                s = exp_stat.pop_front();
                chk("done_cycle", cyc, s.done_cyc);
                chk("err_cnt", int'(err_cnt_o), s.err);
                chk("pass", int'(pass_o), int'(s.pass));
                chk("timeout", int'(timeout_o), int'(s.tmo));
                chk("busy_at_done", int'(busy_o), 0);
                chk("valid_at_done", int'(valid_o), 0);
                if (s.err != 0) chk("fail_addr", int'(fail_addr_o), s.faddr);
            end
        end
        done_prev = (done_o === 1'b1);
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_wr_rd"}, int'(wr_rd_o), 0);
        chk({tag, "_addr"}, int'(addr_o), 0);
        chk({tag, "_wdata"}, int'(wdata_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_pass"}, int'(pass_o), 0);
        chk({tag, "_err"}, int'(err_cnt_o), 0);
        chk({tag, "_faddr"}, int'(fail_addr_o), 0);
        chk({tag, "_tmo"}, int'(timeout_o), 0);
    endtask

    // Reference model of one run: expected request stream and final status.
    task automatic build_expect(input int seed, input bit flt, input bit tmo_mode, output stat_t s);
        int e, rb, lat;
        s.err = 0; s.faddr = 0; s.tmo = tmo_mode;
        if (tmo_mode) begin
            exp_txn.push_back('{1'b1, 0, seed & 255});
            s.pass = 1'b0;
            s.done_cyc = 1 + TMO;
            return;
        end
        for (int a = 0; a < DEPTH; a++) exp_txn.push_back('{1'b1, a, (seed + a) % 256});
        for (int a = 0; a < DEPTH; a++) exp_txn.push_back('{1'b0, a, 0});
        for (int a = 0; a < DEPTH; a++) begin
            e  = (seed + a) % 256;
            rb = e;
            if (flt && a == 5) rb = e & 8'hFE;
            if (flt && a == 9) rb = 8'hFF;
            if (rb != e) begin
                if (s.err == 0) s.faddr = a;
                s.err++;
            end
        end
        lat = 0;
        for (int i = 0; i < 2*DEPTH; i++) lat += 2 + dl[i];
        s.pass = (s.err == 0);
        s.done_cyc = lat;
    endtask

    task automatic issue_start(input int seed, input stat_t s, input bit push);
        int c0;
        @(negedge clk);
        start_i = 1'b1;
        seed_i  = 8'(seed);
        @(posedge clk);
        #1;
        c0 = cyc;
        s.done_cyc = c0 + s.done_cyc;
        if (push) exp_stat.push_back(s);
        chk("start_busy", int'(busy_o), 1);
        chk("start_done_clr", int'(done_o), 0);
        chk("start_err_clr", int'(err_cnt_o), 0);
        chk("start_tmo_clr", int'(timeout_o), 0);
        chk("start_pass_clr", int'(pass_o), 0);
        @(negedge clk);
        start_i = 1'b0;
        seed_i  = 8'($urandom);
    endtask

    task automatic run(input int seed, input bit flt, input bit tmo_mode,
                       input bit use_dly, input bit pulse_busy);
        stat_t s;
        int    n, pulse_at;
        fault   = flt;
        tie_low = tmo_mode;
        mem_txn = 0;
        for (int i = 0; i < 2*DEPTH; i++) dl[i] = use_dly ? int'($urandom_range(0, 3)) : 0;
        build_expect(seed, flt, tmo_mode, s);
        issue_start(seed, s, 1'b1);
        pulse_at = int'($urandom_range(3, 30));
        n = 0;
        while (done_o !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            start_i = (pulse_busy && n == pulse_at && done_o !== 1'b1);
            seed_i  = 8'($urandom);
        end
        start_i = 1'b0;
        chk("done_reached", int'(done_o === 1'b1), 1);
        repeat (12) @(negedge clk);
        chk("done_held", int'(done_o), 1);
        chk("txn_left", exp_txn.size(), 0);
        chk("stat_left", exp_stat.size(), 0);
        exp_txn.delete();
        exp_stat.delete();
    endtask

    task automatic reset_mid_run();
        stat_t s;
        int    n;
        bit    found;
        fault = 1'b0; tie_low = 1'b0; mem_txn = 0;
        for (int i = 0; i < 2*DEPTH; i++) dl[i] = 0;
        build_expect(8'h3C, 1'b0, 1'b0, s);
        issue_start(8'h3C, s, 1'b1);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            found = (valid_o === 1'b1 && wr_rd_o === 1'b1 && addr_o == 4'd7);
        end
        chk("reach_idx7", int'(found), 1);
        @(posedge clk);
        #2;
        exp_txn.delete();
        exp_stat.delete();
        rst_i = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", int'(busy_o), 0);
        chk("post_rst_done", int'(done_o), 0);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        seed_i  = '0;
        ready_i = 1'b0;
        rdata_i = '0;
        for (int i = 0; i < 2*DEPTH; i++) dl[i] = 0;
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        run(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run(8'hF8, 1'b0, 1'b0, 1'b0, 1'b0);
        run(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        run(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        run(int'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
        run(int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        reset_mid_run();
        for (int r = 0; r < 6; r++) begin
            run(int'($urandom_range(0, 255)), 1'($urandom), 1'b0, 1'b1, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Initiator for the single-port valid/ready memory: drives its `valid`/`wr_rd`/`addr`/`wdata` inputs and consumes its `ready`/`rdata` outputs. On `start_i` it writes a seed-derived pattern to every location, reads every location back, compares each word against the expected pattern and reports pass/fail, error count, first failing address and a handshake timeout. It sits between system control and the memory instance as a built-in self-test sequencer.

## Interface
- `DEPTH`, 16, number of memory words addressed
- `WIDTH`, 8, data width in bits
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width
- `TIMEOUT`, 8, consecutive wait cycles with `ready_i` low before a transaction is declared lost (≥1)

- `clk_i`  in  1  clock; all state changes on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  start request, sampled only in IDLE or DONE
- `seed_i`  in  WIDTH  pattern seed, captured on accepted start
- `ready_i`  in  1  memory ready
- `rdata_i`  in  WIDTH  memory read data, valid when `ready_i`=1 after a read issue
- `valid_o`  out  1  transaction request to memory
- `wr_rd_o`  out  1  1 = write, 0 = read
- `addr_o`  out  ADDR_WIDTH  transaction address
- `wdata_o`  out  WIDTH  write data
- `busy_o`  out  1  sequence in progress
- `done_o`  out  1  sequence finished; level, held until next accepted start
- `pass_o`  out  1  valid with `done_o`: no mismatch and no timeout
- `err_cnt_o`  out  ADDR_WIDTH+1  number of read mismatches (max DEPTH)
- `fail_addr_o`  out  ADDR_WIDTH  address of first mismatch; meaningful only when `err_cnt_o`≠0
- `timeout_o`  out  1  handshake timeout occurred

## Operation
- Pattern: expected(a) = (seed + a) mod 2^WIDTH, `a` zero-extended or truncated to WIDTH.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE. Index register `idx` (ADDR_WIDTH bits).
- IDLE/DONE: `start_i`=1 → capture seed, clear `idx`, `err_cnt_o`, `fail_addr_o`, `timeout_o`, `done_o`, `pass_o`; go WR_ISSUE. `start_i` in any other state is ignored.
- WR_ISSUE (one cycle): `valid_o`=1, `wr_rd_o`=1, `addr_o`=idx, `wdata_o`=expected(idx) → WR_WAIT.
- WR_WAIT: `valid_o`=0, `addr_o`/`wdata_o`/`wr_rd_o` held. `ready_i`=1 → if idx=DEPTH-1, idx←0, go RD_ISSUE; else idx+1, go WR_ISSUE.
- RD_ISSUE (one cycle): `valid_o`=1, `wr_rd_o`=0, `addr_o`=idx → RD_WAIT.
- RD_WAIT: `valid_o`=0. `ready_i`=1 → compare `rdata_i` with expected(idx); on mismatch increment `err_cnt_o` and, if it was 0, load `fail_addr_o`←idx. Then idx=DEPTH-1 → DONE, else idx+1 → RD_ISSUE.
- Timeout: wait counter cleared on entry to either WAIT state, increments each WAIT cycle with `ready_i`=0; on reaching TIMEOUT → `timeout_o`=1, go DONE immediately (remaining transactions abandoned).
- DONE: `done_o`=1, `busy_o`=0, `pass_o`=(err_cnt=0 && !timeout), `valid_o`=0.
- `busy_o`=1 in all states except IDLE and DONE.
- `ready_i`/`rdata_i` ignored outside WAIT states; a `ready_i` seen in an ISSUE state is stale and not counted.

## Timing
- Memory contract: memory samples `valid_o` at edge N, asserts `ready_i` with `rdata_i` after edge N, deasserts after N+1 since `valid_o` is low.
- Each transaction = 2 cycles (ISSUE, WAIT) with a zero-wait memory; full sequence 4·DEPTH cycles. Start sampled at edge k → `done_o`=1 after edge k+4·DEPTH (k+64 at defaults).
- Status outputs are registered; mismatch reflected in `err_cnt_o` the cycle after `ready_i`.
- Reset (async, `rst_i`=0), regardless of state: state IDLE, `valid_o`=0, `wr_rd_o`=0, `addr_o`=0, `wdata_o`=0, `busy_o`=0, `done_o`=0, `pass_o`=0, `err_cnt_o`=0, `fail_addr_o`=0, `timeout_o`=0. Mid-sequence reset abandons the run; no further memory requests until a new start.
- Start and ready in the same cycle while in DONE: start wins; ready ignored.

## Test plan
- Reset: assert `rst_i`=0 mid-write at idx 7 → all outputs 0 immediately, no `valid_o` pulse until next start.
- Clean run, seed 8'h00, zero-wait memory model → writes addr a with data a, `done_o` after 64 cycles, `pass_o`=1, `err_cnt_o`=0.
- Wrap, seed 8'hF8 → addr 10 written 8'h02, addr 15 written 8'h07; `pass_o`=1.
- Faults: model forces bit 0 of addr 5 to 0 and addr 9 read to 8'hFF (seed 8'h00) → `err_cnt_o`=2, `fail_addr_o`=5, `pass_o`=0.
- Timeout: `ready_i` tied 0 → one `valid_o` pulse (write, addr 0), `timeout_o`=1 and `done_o`=1 after 8 WAIT cycles, `pass_o`=0, no further requests.
- Start handling: `start_i` pulsed while busy ignored (done still at 64 cycles); start from DONE clears status and reruns.
